// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch sequencer, its program ROM and the decode/execute stage.
// master = fetch_unit side, slave = ROM plus downstream consumer side.
interface fetch_unit_if #(
    parameter int ADDR_W = 16
) ();
    logic              o_rom_en;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [7:0]        i_rom_data;
    logic              o_valid;
    logic              i_ready;
    logic [7:0]        o_opcode;
    logic [7:0]        o_operand;
    logic              o_len2;
    logic [ADDR_W-1:0] o_pc_next;
    logic              i_jump_valid;
    logic [ADDR_W-1:0] i_jump_addr;

    modport master (
        output o_rom_en, o_rom_addr, o_valid, o_opcode, o_operand, o_len2, o_pc_next,
        input  i_rom_data, i_ready, i_jump_valid, i_jump_addr
    );

    modport slave (
        input  o_rom_en, o_rom_addr, o_valid, o_opcode, o_operand, o_len2, o_pc_next,
        output i_rom_data, i_ready, i_jump_valid, i_jump_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// 8051 instruction fetch sequencer: owns the PC, reads a 1-cycle-latency ROM and hands
// assembled one/two-byte instructions downstream over valid/ready; accepts PC redirects.
//   state    | meaning
//   S_FETCH1 | ROM read of opcode at PC
//   S_WAIT1  | opcode returns, length decoded
//   S_FETCH2 | ROM read of operand at PC+1
//   S_WAIT2  | operand returns
//   S_HOLD   | instruction presented, waiting for i_ready
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH1,
        S_WAIT1,
        S_FETCH2,
        S_WAIT2,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        operand_q, operand_d;
    logic              len2_q, len2_d;
    logic [ADDR_W-1:0] pc_inc1, pc_inc2;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic              data_len2;

    assign pc_inc1 = pc_q + ADDR_W'(1);
    assign pc_inc2 = pc_q + ADDR_W'(2);

    // Immediate/direct forms (low nibble 4 or 5) plus the four conditional rel jumps
    assign data_len2 = (bus.i_rom_data[3:0] == 4'h4) || (bus.i_rom_data[3:0] == 4'h5) ||
                       (bus.i_rom_data inside {8'h40, 8'h50, 8'h60, 8'h70});

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len2_d    = len2_q;
        rom_en    = 1'b0;
        rom_addr  = pc_q;

        case (state_q)
            S_FETCH1: begin
                rom_en  = 1'b1;
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                opcode_d = bus.i_rom_data;
                len2_d   = data_len2;
                if (data_len2) begin
                    state_d = S_FETCH2;
                end else begin
                    operand_d = 8'h00;
                    pc_next_d = pc_inc1;
                    state_d   = S_HOLD;
                end
            end
            S_FETCH2: begin
                rom_en   = 1'b1;
                rom_addr = pc_inc1;
                state_d  = S_WAIT2;
            end
            S_WAIT2: begin
                operand_d = bus.i_rom_data;
                pc_next_d = pc_inc2;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (bus.i_ready) begin
                    pc_d    = pc_next_q;
                    state_d = S_FETCH1;
                end
            end
            default: state_d = S_FETCH1;
        endcase

        // Redirect wins over everything, including a same-cycle accept
        if (bus.i_jump_valid) begin
            pc_d    = bus.i_jump_addr;
            state_d = S_FETCH1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_FETCH1;
            pc_q      <= RESET_PC;
            pc_next_q <= RESET_PC;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            len2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len2_q    <= len2_d;
        end
    end

    // Reset state is S_FETCH1, so the strobe is masked to keep the ROM idle while held in reset
    assign bus.o_rom_en   = rom_en & i_rst_n;
    assign bus.o_rom_addr = rom_addr;
    assign bus.o_valid    = (state_q == S_HOLD);
    assign bus.o_opcode   = opcode_q;
    assign bus.o_operand  = operand_q;
    assign bus.o_len2     = len2_q;
    assign bus.o_pc_next  = pc_next_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a ROM model, a reference instruction model driven by a
// queue of expected instructions, directed scenarios followed by randomized ready/redirects.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(16)) bus ();

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    logic [7:0] rom [0:65535];
    always @(posedge clk) if (bus.o_rom_en) bus.i_rom_data <= rom[bus.o_rom_addr];

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] pc1;
        logic [7:0]  op;
        logic [7:0]  opd;
        logic        len2;
        logic [15:0] pc_next;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    exp_t h;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    bit   mon_en = 1'b0;

    function automatic bit two_byte(logic [7:0] op);
        logic [3:0] lo;
        lo = op[3:0];
        return (lo == 4'h4) || (lo == 4'h5) ||
               (op == 8'h40) || (op == 8'h50) || (op == 8'h60) || (op == 8'h70);
    endfunction

    // Expected instruction at pc; start = cycle index of its S_FETCH1 cycle
    function automatic exp_t make_exp(logic [15:0] pc, int start);
        exp_t e;
        e.pc      = pc;
        e.pc1     = pc + 16'd1;
        e.op      = rom[pc];
        e.len2    = two_byte(e.op);
        e.opd     = e.len2 ? rom[e.pc1] : 8'h00;
        e.pc_next = e.len2 ? pc + 16'd2 : pc + 16'd1;
        e.start   = start;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && exp_q.size() > 0) begin
            h = exp_q[0];
            if (cnt >= h.start) begin
                chk("valid", 32'(bus.o_valid), 32'(cnt >= h.start + (h.len2 ? 4 : 2)));
                chk("rom_en", 32'(bus.o_rom_en),
                    32'((cnt == h.start) || (h.len2 && cnt == h.start + 2)));
                chk("rom_addr", 32'(bus.o_rom_addr),
                    32'((h.len2 && cnt == h.start + 2) ? h.pc1 : h.pc));
                if (bus.o_valid) begin
                    chk("opcode", 32'(bus.o_opcode), 32'(h.op));
                    chk("operand", 32'(bus.o_operand), 32'(h.opd));
                    chk("len2", 32'(bus.o_len2), 32'(h.len2));
                    chk("pc_next", 32'(bus.o_pc_next), 32'(h.pc_next));
                    if (bus.i_ready && !bus.i_jump_valid) begin
                        void'(exp_q.pop_front());
                        exp_q.push_back(make_exp(h.pc_next, cnt + 1));
                        n_xfer++;
                    end
                end
            end
        end
    end

    task automatic jump_now(input logic [15:0] a);
        bus.i_jump_valid = 1'b1;
        bus.i_jump_addr  = a;
        exp_q.delete();
        exp_q.push_back(make_exp(a, cnt + 1));
        @(posedge clk); #1;
        bus.i_jump_valid = 1'b0;
    endtask

    task automatic chk_reset_values();
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_opcode", 32'(bus.o_opcode), 32'h0);
        chk("rst_operand", 32'(bus.o_operand), 32'h0);
        chk("rst_len2", 32'(bus.o_len2), 32'h0);
        chk("rst_pc_next", 32'(bus.o_pc_next), 32'h0);
        chk("rst_rom_en", 32'(bus.o_rom_en), 32'h0);
    endtask

    initial begin
        logic [15:0] a;
        rst_n            = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_jump_valid = 1'b0;
        bus.i_jump_addr  = 16'h0000;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'h0000] = 8'hE8;
        rom[16'h0001] = 8'h24;
        rom[16'h0002] = 8'h05;
        rom[16'hFFFF] = 8'h74;
        rom[16'h0200] = 8'h74;
        rom[16'h0123] = 8'hE8;
        #1;
        chk_reset_values();

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_q.push_back(make_exp(16'h0000, cnt));
        mon_en = 1'b1;

        // Back-to-back accept, then a long stall while an instruction is held
        bus.i_ready = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        bus.i_ready = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        bus.i_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        // Redirect during S_WAIT2, then redirect racing an accept in S_HOLD
        jump_now(16'h0200);
        repeat (3) begin @(posedge clk); #1; end
        jump_now(16'h0123);
        repeat (2) begin @(posedge clk); #1; end
        jump_now(16'h0040);
        repeat (10) begin @(posedge clk); #1; end

        // Operand fetch wraps past the top of the address space
        jump_now(16'hFFFF);
        repeat (10) begin @(posedge clk); #1; end

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = 16'hFFFF;
                    1:       a = 16'h0040;
                    2:       a = 16'h0123;
                    default: a = 16'($urandom);
                endcase
                bus.i_jump_valid = 1'b1;
                bus.i_jump_addr  = a;
                exp_q.delete();
                exp_q.push_back(make_exp(a, cnt + 1));
            end else begin
                bus.i_jump_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.i_jump_valid = 1'b0;
        bus.i_ready      = 1'b1;

        // Asynchronous reset landing in S_FETCH2
        jump_now(16'h0200);
        repeat (2) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_values();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_q.push_back(make_exp(16'h0000, cnt));
        mon_en = 1'b1;
        repeat (20) begin @(posedge clk); #1; end

        chk("transfers_seen", 32'(n_xfer >= 100), 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8051 core. It owns the program counter, and drives a synchronous ROM with one cycle of read latency. It assembles one- or two-byte instructions into an opcode/operand pair and presents them to the opcode decoder and execute stage through a valid/ready handshake. It also accepts PC redirects from execute for jumps, RETI and interrupt entry.

## Interface
- ADDR_W, 16, PC and ROM address width
- RESET_PC, 0, PC value loaded on reset
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- o_rom_en  out  1  ROM read strobe
- o_rom_addr  out  ADDR_W  ROM read address
- i_rom_data  in  8  ROM read data; valid the cycle after o_rom_en
- o_valid  out  1  o_opcode/o_operand/o_pc_next hold a complete instruction
- i_ready  in  1  downstream accepts the instruction this cycle
- o_opcode  out  8  instruction byte 0 (feeds decoder i_opcode)
- o_operand  out  8  instruction byte 1; 0x00 for one-byte instructions
- o_len2  out  1  1 = two-byte instruction
- o_pc_next  out  ADDR_W  address following the instruction (base for relative jumps)
- i_jump_valid  in  1  redirect request
- i_jump_addr  in  ADDR_W  redirect target

## Operation
- Length rule:
  - Two-byte if opcode[3:0] is 4'h4 or 4'h5 (immediate/direct forms, including MOV direct,A = 0xF5).
  - Two-byte if opcode is 0x40, 0x50, 0x60 or 0x70 (JC/JNC/JZ/JNZ rel).
  - All other opcodes are one-byte, including Rn forms, RETI 0x32 and unknown opcodes.
- FSM states: S_FETCH1, S_WAIT1, S_FETCH2, S_WAIT2, S_HOLD. Reset enters S_FETCH1.
- S_FETCH1: o_rom_en=1, o_rom_addr=PC. Next state is S_WAIT1.
- S_WAIT1: o_rom_en=0. Latch i_rom_data into o_opcode and compute o_len2.
  - Two-byte: go to S_FETCH2.
  - One-byte: set o_operand=0x00, o_pc_next=PC+1, and go to S_HOLD.
- S_FETCH2: o_rom_en=1, o_rom_addr=PC+1. Next state is S_WAIT2.
- S_WAIT2: latch i_rom_data into o_operand, set o_pc_next=PC+2, and go to S_HOLD.
- S_HOLD: o_valid=1.
  - o_opcode, o_operand, o_len2 and o_pc_next stay stable until accepted.
  - On i_ready=1: PC<=o_pc_next and go to S_FETCH1.
- Redirect: i_jump_valid=1 in any state sets PC<=i_jump_addr, clears o_valid and goes to S_FETCH1.
  - ROM data returning in the same or following cycle is discarded.
  - Redirect has priority over i_ready in the same cycle; the PC takes i_jump_addr, not o_pc_next.
- Arithmetic: PC+1 and PC+2 are computed modulo 2^ADDR_W. For ADDR_W=16, 0xFFFF+1 = 0x0000 and 0xFFFF+2 = 0x0001. The PC in the ROM address path is the same modulo value.
- When not in a fetch state, o_rom_addr shows the PC.

## Timing
- Reset values (asynchronous):
  - state S_FETCH1, PC=RESET_PC
  - o_valid=0, o_opcode=0x00, o_operand=0x00, o_len2=0, o_pc_next=RESET_PC
  - o_rom_en=0 while i_rst_n is low; o_rom_en=1 in the first cycle after release (S_FETCH1)
- Latency, counted from the S_FETCH1 cycle as cycle 0:
  - One-byte instruction: o_valid high in cycle 2.
  - Two-byte instruction: o_valid high in cycle 4.
- Throughput with i_ready held at 1: one instruction per 3 cycles (one-byte) or per 5 cycles (two-byte).
- Handshake:
  - A transfer occurs on a rising edge with o_valid=1, i_ready=1 and i_jump_valid=0.
  - o_valid drops the cycle after a transfer.
  - i_ready while o_valid=0 is ignored.
- Redirect timing: i_jump_valid sampled at edge t gives o_rom_en=1 with o_rom_addr=i_jump_addr in cycle t+1.
- Reset mid-fetch: any outstanding ROM read is abandoned. Fetch restarts at RESET_PC after release.

## Test plan
- ROM[0]=0xE8, ROM[1]=0x24, ROM[2]=0x05, i_ready=1 after reset.
  - First transfer: o_opcode=0xE8, o_operand=0x00, o_pc_next=0x0001, cycle 2.
  - Second transfer: o_opcode=0x24, o_operand=0x05, o_len2=1, o_pc_next=0x0003, 5 cycles later.
- Stall: i_ready=0 for 10 cycles while o_valid=1.
  - Outputs stay constant and o_rom_en stays 0.
  - Raising i_ready yields exactly one transfer, then o_rom_addr=o_pc_next.
- Redirect: i_jump_valid=1, i_jump_addr=0x0123 asserted during S_WAIT2 of a two-byte fetch.
  - The partial instruction is never presented.
  - The next o_rom_addr is 0x0123.
- Simultaneous i_ready=1 and i_jump_valid=1 (addr 0x0040) in S_HOLD:
  - PC becomes 0x0040, not o_pc_next.
  - o_valid=0 on the next cycle.
- Wrap-around: RESET_PC=0xFFFF, ROM[0xFFFF]=0x74, ROM[0x0000]=0x10.
  - The second read address is 0x0000.
  - Outputs are o_opcode=0x74, o_operand=0x10, o_pc_next=0x0001.
- Assert i_rst_n low during S_FETCH2.
  - All outputs take their reset values immediately, without a clock edge.
  - After release, fetch resumes at RESET_PC.
